vending_machine: RTL and testbench

- Single-clock vending controller for a 3x3 product grid (slots A1..C3).
- Accepts coin/bill button pulses and accumulates credit in cents; vends on a selection press when credit covers the price; returns change on request.
- Drives per-slot green/red LEDs and a 32-bit BCD word feeding the board's 8-digit seven-segment driver.
- Top-level user-facing block; the seven-segment scan driver lives outside.

---
 rtl/vending_pkg.sv | 61 ++++++
 rtl/vm_bin2bcd.sv | 25 ++
 rtl/vending_machine.sv | 259 +++++++++++++++++++++++++
 tb/tb_vending_machine.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared constants for the vending controller: button map, coin values,
// slot prices and credit ceiling.
package vending_pkg;

    localparam int NUM_SLOTS = 9;
    localparam int NUM_COINS = 6;
    localparam int NUM_BTN   = 17;

    localparam logic [13:0] CREDIT_MAX = 14'd9995;

    // Button vector order doubles as event priority: bit 0 wins.
    localparam logic [4:0] BTN_CANCEL = 5'd0;
    localparam logic [4:0] BTN_DISP   = 5'd1;
    localparam logic [4:0] BTN_COIN0  = 5'd2;
    localparam logic [4:0] BTN_SLOT0  = 5'd8;

    localparam logic [3:0] SLOT_A1 = 4'd0;
    localparam logic [3:0] SLOT_A2 = 4'd1;
    localparam logic [3:0] SLOT_A3 = 4'd2;
    localparam logic [3:0] SLOT_B1 = 4'd3;
    localparam logic [3:0] SLOT_B2 = 4'd4;
    localparam logic [3:0] SLOT_B3 = 4'd5;
    localparam logic [3:0] SLOT_C1 = 4'd6;
    localparam logic [3:0] SLOT_C2 = 4'd7;
    localparam logic [3:0] SLOT_C3 = 4'd8;

    typedef logic [2:0] stock_t;

    // Coins ordered five, dollar, fifty, quarter, dime, nickel.
    function automatic logic [13:0] coin_value(input logic [2:0] c);
        logic [13:0] v;
        case (c)
            3'd0:    v = 14'd500;
            3'd1:    v = 14'd100;
            3'd2:    v = 14'd50;
            3'd3:    v = 14'd25;
            3'd4:    v = 14'd10;
            3'd5:    v = 14'd5;
            default: v = 14'd0;
        endcase
        return v;
    endfunction

    function automatic logic [13:0] slot_price(input logic [3:0] s);
        logic [13:0] p;
        case (s)
            SLOT_A1: p = 14'd125;
            SLOT_A2: p = 14'd150;
            SLOT_A3: p = 14'd175;
            SLOT_B1: p = 14'd100;
            SLOT_B2: p = 14'd200;
            SLOT_B3: p = 14'd225;
            SLOT_C1: p = 14'd250;
            SLOT_C2: p = 14'd300;
            SLOT_C3: p = 14'd500;
            default: p = 14'd0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/vm_bin2bcd.sv
// Combinational 14-bit binary to four BCD digits (double dabble).
// Inputs are bounded to 0..9999 by the controller.
module vm_bin2bcd
    import vending_pkg::*;
(
    input  logic [13:0] bin_i,
    output logic [15:0] bcd_o
);

    logic [29:0] sr;

    always_comb begin
        sr = {16'd0, bin_i};
        for (int i = 0; i < 14; i++) begin
            for (int d = 0; d < 4; d++) begin
                if (sr[14 + 4*d +: 4] >= 4'd5) begin
                    sr[14 + 4*d +: 4] = sr[14 + 4*d +: 4] + 4'd3;
                end
            end
            sr = {sr[28:0], 1'b0};
        end
        bcd_o = sr[29:14];
    end

endmodule

// File: rtl/vending_machine.sv
// 3x3 vending controller: conditioned button events, credit/stock state,
// slot LEDs and a registered BCD display word.
module vending_machine
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int STOCK_INIT      = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        A1,
    input  logic        A2,
    input  logic        A3,
    input  logic        B1,
    input  logic        B2,
    input  logic        B3,
    input  logic        C1,
    input  logic        C2,
    input  logic        C3,
    input  logic        nickel,
    input  logic        dime,
    input  logic        quarter,
    input  logic        fifty,
    input  logic        dollar,
    input  logic        five,
    input  logic        cancelReset,
    input  logic        coinsDisp,
    output logic        gLEDA1,
    output logic        gLEDA2,
    output logic        gLEDA3,
    output logic        gLEDB1,
    output logic        gLEDB2,
    output logic        gLEDB3,
    output logic        gLEDC1,
    output logic        gLEDC2,
    output logic        gLEDC3,
    output logic        rLEDA1,
    output logic        rLEDA2,
    output logic        rLEDA3,
    output logic        rLEDB1,
    output logic        rLEDB2,
    output logic        rLEDB3,
    output logic        rLEDC1,
    output logic        rLEDC2,
    output logic        rLEDC3,
    output logic [31:0] board7SD
);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;
    logic [NUM_BTN-1:0] deb;
    logic [NUM_BTN-1:0] prev_q;
    logic [NUM_BTN-1:0] ev;

    assign btn_raw = {C3, C2, C1, B3, B2, B1, A3, A2, A1,
                      nickel, dime, quarter, fifty, dollar, five,
                      coinsDisp, cancelReset};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    genvar g;
    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
            assign deb = sync2_q;
        end else begin : g_deb
            localparam int CW = (DEBOUNCE_CYCLES > 1) ?
                                $clog2(DEBOUNCE_CYCLES) : 1;
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
            for (g = 0; g < NUM_BTN; g++) begin : g_bit
                logic [CW-1:0] cnt_q;
                logic          lvl_q;
                // Accept a new level only after it has held long enough.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        cnt_q <= '0;
                        lvl_q <= 1'b0;
                    end else if (sync2_q[g] == lvl_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        lvl_q <= sync2_q[g];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                assign deb[g] = lvl_q;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= deb;
        end
    end

    assign ev = deb & ~prev_q;

    logic [4:0] ev_idx;
    logic       ev_any;

    always_comb begin
        ev_idx = '0;
        ev_any = |ev;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (ev[i]) begin
                ev_idx = 5'(i);
            end
        end
    end

    logic [13:0] credit_q, credit_d;
    logic [3:0]  sel_q, sel_d;
    logic [13:0] change_q, change_d;
    logic        show_q, show_d;
    stock_t      stock_q [NUM_SLOTS];
    stock_t      stock_d [NUM_SLOTS];

    logic        is_cancel, is_disp, is_coin, is_slot;
    logic [4:0]  coin_off, slot_off;
    logic [2:0]  coin;
    logic [3:0]  slot;
    logic [14:0] sum;
    logic [13:0] price;

    assign coin_off  = ev_idx - BTN_COIN0;
    assign slot_off  = ev_idx - BTN_SLOT0;
    assign coin      = coin_off[2:0];
    assign slot      = slot_off[3:0];
    assign sum       = {1'b0, credit_q} + {1'b0, coin_value(coin)};
    assign price     = slot_price(slot);
    assign is_cancel = ev_any && (ev_idx == BTN_CANCEL);
    assign is_disp   = ev_any && (ev_idx == BTN_DISP);
    assign is_coin   = ev_any && (ev_idx >= BTN_COIN0) &&
                       (ev_idx < BTN_SLOT0);
    assign is_slot   = ev_any && (ev_idx >= BTN_SLOT0);

    always_comb begin
        credit_d = credit_q;
        sel_d    = sel_q;
        change_d = change_q;
        show_d   = show_q;
        stock_d  = stock_q;
        unique case (1'b1)
            is_cancel: begin
                change_d = credit_q;
                credit_d = '0;
                show_d   = 1'b1;
                sel_d    = '0;
            end
            is_disp: begin
                change_d = credit_q;
                credit_d = '0;
                show_d   = 1'b1;
            end
            is_coin: begin
                if (sum <= {1'b0, CREDIT_MAX}) begin
                    credit_d = sum[13:0];
                end
                show_d = 1'b0;
            end
            is_slot: begin
                show_d = 1'b0;
                if (stock_q[slot] != '0) begin
                    if (credit_q >= price) begin
                        credit_d       = credit_q - price;
                        stock_d[slot]  = stock_q[slot] - 3'd1;
                        sel_d          = '0;
                    end else begin
                        sel_d = slot + 4'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q <= '0;
            sel_q    <= '0;
            change_q <= '0;
            show_q   <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                stock_q[i] <= 3'(STOCK_INIT);
            end
        end else begin
            credit_q <= credit_d;
            sel_q    <= sel_d;
            change_q <= change_d;
            show_q   <= show_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    logic [NUM_SLOTS-1:0] gled_d, gled_q;
    logic [NUM_SLOTS-1:0] rled_d, rled_q;

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            gled_d[i] = (stock_d[i] != '0) &&
                        (credit_d >= slot_price(4'(i)));
            rled_d[i] = (stock_d[i] == '0);
        end
    end

    logic [13:0] up_bin;
    logic [15:0] up_bcd, cr_bcd;

    always_comb begin
        up_bin = '0;
        if (show_d) begin
            up_bin = change_d;
        end else if (sel_d != '0) begin
            up_bin = slot_price(sel_d - 4'd1);
        end
    end

    vm_bin2bcd u_up_bcd (
        .bin_i (up_bin),
        .bcd_o (up_bcd)
    );

    vm_bin2bcd u_cr_bcd (
        .bin_i (credit_d),
        .bcd_o (cr_bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gled_q   <= '0;
            rled_q   <= '0;
            board7SD <= '0;
        end else begin
            gled_q   <= gled_d;
            rled_q   <= rled_d;
            board7SD <= {up_bcd, cr_bcd};
        end
    end

    assign {gLEDC3, gLEDC2, gLEDC1, gLEDB3, gLEDB2, gLEDB1,
            gLEDA3, gLEDA2, gLEDA1} = gled_q;
    assign {rLEDC3, rLEDC2, rLEDC1, rLEDB3, rLEDB2, rLEDB1,
            rLEDA3, rLEDA2, rLEDA1} = rled_q;

endmodule

// File: tb/tb_vending_machine.sv
// Self-checking bench for vending_machine: directed scenarios plus
// randomized presses against a behavioural credit/stock model.
module tb_vending_machine;

    localparam int B_CANCEL = 0;
    localparam int B_DISP   = 1;
    localparam int B_FIVE   = 2;
    localparam int B_DOLLAR = 3;
    localparam int B_FIFTY  = 4;
    localparam int B_QUART  = 5;
    localparam int B_DIME   = 6;
    localparam int B_NICKEL = 7;
    localparam int B_A1     = 8;
    localparam int B_B1     = 11;
    localparam int B_C3     = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] btn;
    wire  [31:0] board;
    wire  [8:0]  gled;
    wire  [8:0]  rled;

    int checks = 0;
    int errors = 0;

    int m_credit, m_sel, m_change;
    bit m_show;
    int m_stock [9];
    int price [9] = '{125, 150, 175, 100, 200, 225, 250, 300, 500};
    int coinv [6] = '{500, 100, 50, 25, 10, 5};

    always #5 clk = ~clk;

    vending_machine #(.DEBOUNCE_CYCLES(0), .STOCK_INIT(5)) dut (
        .clk(clk), .rst(rst),
        .A1(btn[8]), .A2(btn[9]), .A3(btn[10]),
        .B1(btn[11]), .B2(btn[12]), .B3(btn[13]),
        .C1(btn[14]), .C2(btn[15]), .C3(btn[16]),
        .nickel(btn[7]), .dime(btn[6]), .quarter(btn[5]),
        .fifty(btn[4]), .dollar(btn[3]), .five(btn[2]),
        .cancelReset(btn[0]), .coinsDisp(btn[1]),
        .gLEDA1(gled[0]), .gLEDA2(gled[1]), .gLEDA3(gled[2]),
        .gLEDB1(gled[3]), .gLEDB2(gled[4]), .gLEDB3(gled[5]),
        .gLEDC1(gled[6]), .gLEDC2(gled[7]), .gLEDC3(gled[8]),
        .rLEDA1(rled[0]), .rLEDA2(rled[1]), .rLEDA3(rled[2]),
        .rLEDB1(rled[3]), .rLEDB2(rled[4]), .rLEDB3(rled[5]),
        .rLEDC1(rled[6]), .rLEDC2(rled[7]), .rLEDC3(rled[8]),
        .board7SD(board)
    );

    function automatic logic [15:0] bcd4(input int v);
        return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 +
                   ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic logic [31:0] exp_board();
        int up;
        up = m_show ? m_change : (m_sel != 0 ? price[m_sel-1] : 0);
        return {bcd4(up), bcd4(m_credit)};
    endfunction

    function automatic logic [8:0] exp_g();
        logic [8:0] g;
        for (int s = 0; s < 9; s++)
            g[s] = (m_stock[s] != 0) && (m_credit >= price[s]);
        return g;
    endfunction

    function automatic logic [8:0] exp_r();
        logic [8:0] r;
        for (int s = 0; s < 9; s++) r[s] = (m_stock[s] == 0);
        return r;
    endfunction

    // Reference rule: the lowest-numbered pressed button is the event.
    task automatic model_event(input logic [16:0] b);
        int k;
        k = -1;
        for (int i = 16; i >= 0; i--) if (b[i]) k = i;
        if (k < 0) return;
        if (k <= B_DISP) begin
            m_change = m_credit;
            m_credit = 0;
            m_show   = 1;
            if (k == B_CANCEL) m_sel = 0;
        end else if (k < B_A1) begin
            if (m_credit + coinv[k-B_FIVE] <= 9995)
                m_credit += coinv[k-B_FIVE];
            m_show = 0;
        end else begin
            int s;
            s = k - B_A1;
            m_show = 0;
            if (m_stock[s] != 0) begin
                if (m_credit >= price[s]) begin
                    m_credit -= price[s];
                    m_stock[s]--;
                    m_sel = 0;
                end else begin
                    m_sel = s + 1;
                end
            end
        end
    endtask

    task automatic press(input logic [16:0] b);
        @(negedge clk);
        btn = b;
        repeat (3) @(posedge clk);
        #1;
        model_event(b);
        btn = '0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic press_n(input int bit_i, input int n);
        logic [16:0] b;
        b = '0;
        b[bit_i] = 1'b1;
        for (int i = 0; i < n; i++) press(b);
    endtask

    task automatic do_reset();
        btn = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_credit = 0;
        m_sel    = 0;
        m_change = 0;
        m_show   = 0;
        for (int s = 0; s < 9; s++) m_stock[s] = 5;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (board !== 32'h0) begin
            errors++;
            $display("FAIL reset_board got %h want %h", board, 32'h0);
        end
        checks++;
        if (gled !== 9'h0 || rled !== 9'h0) begin
            errors++;
            $display("FAIL reset_leds got g=%b r=%b want 0", gled, rled);
        end
    endtask

    task automatic test_select_vend();
        press_n(B_A1, 1);
        checks++;
        if (board !== 32'h01250000 || gled[0] !== 1'b0) begin
            errors++;
            $display("FAIL select_a1 got %h g=%b want 01250000 g0=0",
                     board, gled);
        end
        press_n(B_DOLLAR, 5);
        press_n(B_QUART, 1);
        checks++;
        if (board !== 32'h01250525 || gled !== 9'h1ff) begin
            errors++;
            $display("FAIL credit_525 got %h g=%b want 01250525 g=1ff",
                     board, gled);
        end
        press_n(B_A1, 1);
        checks++;
        if (board !== 32'h00000400 || m_stock[0] != 4) begin
            errors++;
            $display("FAIL vend_a1 got %h want 00000400 stock=%0d",
                     board, m_stock[0]);
        end
        press_n(B_DISP, 1);
        checks++;
        if (board !== 32'h04000000) begin
            errors++;
            $display("FAIL coins_disp got %h want 04000000", board);
        end
    endtask

    task automatic test_soldout();
        do_reset();
        press_n(B_FIVE, 1);
        press_n(B_B1, 5);
        checks++;
        if (rled[3] !== 1'b1 || gled[3] !== 1'b0 || board !== 32'h0) begin
            errors++;
            $display("FAIL soldout_b1 got r=%b g=%b %h want r3=1 g3=0 0",
                     rled, gled, board);
        end
        press_n(B_DOLLAR, 1);
        press_n(B_B1, 1);
        checks++;
        if (board !== 32'h00000100 || rled[3] !== 1'b1) begin
            errors++;
            $display("FAIL soldout_press got %h want 00000100", board);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        press_n(B_FIVE, 19);
        press_n(B_DOLLAR, 4);
        checks++;
        if (board !== 32'h00009900) begin
            errors++;
            $display("FAIL credit_9900 got %h want 00009900", board);
        end
        press_n(B_FIVE, 1);
        checks++;
        if (board !== 32'h00009900) begin
            errors++;
            $display("FAIL overflow_reject got %h want 00009900", board);
        end
        press_n(B_NICKEL, 1);
        checks++;
        if (board !== 32'h00009905) begin
            errors++;
            $display("FAIL nickel_9905 got %h want 00009905", board);
        end
    endtask

    task automatic test_simultaneous();
        logic [16:0] b;
        do_reset();
        b = '0;
        b[B_DOLLAR] = 1'b1;
        b[B_NICKEL] = 1'b1;
        press(b);
        checks++;
        if (board !== 32'h00000100) begin
            errors++;
            $display("FAIL dollar_nickel got %h want 00000100", board);
        end
        press_n(B_FIFTY, 1);
        press_n(B_C3, 1);
        checks++;
        if (board !== 32'h05000150) begin
            errors++;
            $display("FAIL sel_c3 got %h want 05000150", board);
        end
        press_n(B_CANCEL, 1);
        checks++;
        if (board !== 32'h01500000) begin
            errors++;
            $display("FAIL cancel got %h want 01500000", board);
        end
        press_n(B_DOLLAR, 1);
        checks++;
        if (board !== 32'h00000100) begin
            errors++;
            $display("FAIL sel_cleared got %h want 00000100", board);
        end
    endtask

    task automatic test_held();
        do_reset();
        @(negedge clk);
        btn = '0;
        btn[B_NICKEL] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (board !== 32'h0) begin
            errors++;
            $display("FAIL latency_early got %h want 00000000", board);
        end
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (board !== 32'h00000005) begin
            errors++;
            $display("FAIL held_once got %h want 00000005", board);
        end
        btn = '0;
        m_credit = 5;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [16:0] b;
        int r;
        do_reset();
        for (int n = 0; n < 250; n++) begin
            b = '0;
            r = $urandom_range(0, 99);
            if (r < 4)       b[B_CANCEL] = 1'b1;
            else if (r < 8)  b[B_DISP] = 1'b1;
            else if (r < 55) b[$urandom_range(B_FIVE, B_NICKEL)] = 1'b1;
            else             b[$urandom_range(B_A1, B_C3)] = 1'b1;
            if ($urandom_range(0, 9) == 0) b[$urandom_range(0, 16)] = 1'b1;
            press(b);
            checks++;
            if (board !== exp_board() || gled !== exp_g() ||
                rled !== exp_r()) begin
                errors++;
                $display("FAIL rand_%0d btn=%h got %h g=%b r=%b want %h g=%b r=%b",
                         n, b, board, gled, rled,
                         exp_board(), exp_g(), exp_r());
            end
        end
    endtask

    initial begin
        btn = '0;
        rst = 1'b0;
        test_reset();
        test_select_vend();
        test_soldout();
        test_overflow();
        test_simultaneous();
        test_held();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
